// File: rtl/ysyx_25010008_axi_pkg.sv
// rtl/ysyx_25010008_axi_pkg.sv - AXI4-Lite response codes and arbiter state encoding
package ysyx_25010008_axi_pkg;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t M0_RD = 2'd1;
  localparam arb_state_t M1_RD = 2'd2;
  localparam arb_state_t M1_WR = 2'd3;

endpackage

// File: rtl/ysyx_25010008_bus_watchdog.sv
// rtl/ysyx_25010008_bus_watchdog.sv - saturating open-transaction counter with sticky expiry flag
module ysyx_25010008_bus_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // expired sets on the tick that brings count to LIMIT; only reset clears it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (tick && count != LIMIT) begin
        count <= count + 1'b1;
      end
      if (tick && !clear && count >= LIMIT - 1'b1) begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_25010008_mem_arbiter.sv
// rtl/ysyx_25010008_mem_arbiter.sv - round-robin AXI4-Lite arbiter: IFU (read) and LSU (read/write) onto one slave
module ysyx_25010008_mem_arbiter
  import ysyx_25010008_axi_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                m0_arvalid,
  input  logic [ADDR_W-1:0]   m0_araddr,
  output logic                m0_arready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  input  logic                m0_rready,
  input  logic                m1_arvalid,
  input  logic [ADDR_W-1:0]   m1_araddr,
  output logic                m1_arready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  input  logic                m1_rready,
  input  logic                m1_awvalid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  output logic                m1_awready,
  input  logic                m1_wvalid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_wready,
  output logic                m1_bvalid,
  output logic [1:0]          m1_bresp,
  input  logic                m1_bready,
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arready,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  output logic                s_rready,
  output logic                s_awvalid,
  output logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awready,
  output logic                s_wvalid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wready,
  input  logic                s_bvalid,
  input  logic [1:0]          s_bresp,
  output logic                s_bready,
  output logic                err_timeout
);

  arb_state_t state, state_next;
  logic       last_m1, last_m1_next;
  logic       req0, req1, grant0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_next;
      last_m1 <= last_m1_next;
    end
  end

  assign req0   = m0_arvalid;
  assign req1   = m1_arvalid | m1_awvalid;
  // on a tie the master that was not granted last time wins
  assign grant0 = req0 && (!req1 || last_m1);

  always_comb begin
    state_next   = state;
    last_m1_next = last_m1;
    case (state)
      IDLE: begin
        if (grant0) begin
          state_next   = M0_RD;
          last_m1_next = 1'b0;
        end else if (req1) begin
          state_next   = m1_awvalid ? M1_WR : M1_RD;
          last_m1_next = 1'b1;
        end
      end
      M0_RD:   if (s_rvalid && m0_rready) state_next = IDLE;
      M1_RD:   if (s_rvalid && m1_rready) state_next = IDLE;
      M1_WR:   if (s_bvalid && m1_bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = OKAY;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = OKAY;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = OKAY;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_bready   = 1'b0;
    case (state)
      M0_RD: begin
        s_arvalid  = m0_arvalid;
        s_araddr   = m0_araddr;
        m0_arready = s_arready;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        s_rready   = m0_rready;
      end
      M1_RD: begin
        s_arvalid  = m1_arvalid;
        s_araddr   = m1_araddr;
        m1_arready = s_arready;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        s_rready   = m1_rready;
      end
      M1_WR: begin
        s_awvalid  = m1_awvalid;
        s_awaddr   = m1_awaddr;
        m1_awready = s_awready;
        s_wvalid   = m1_wvalid;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        m1_wready  = s_wready;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

  ysyx_25010008_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == IDLE),
    .tick   (state != IDLE),
    .expired(err_timeout)
  );

endmodule

// File: tb/tb_ysyx_25010008_mem_arbiter.sv
// tb/tb_ysyx_25010008_mem_arbiter.sv - directed self-checking bench for the memory arbiter
module tb_ysyx_25010008_mem_arbiter;
  import ysyx_25010008_axi_pkg::*;

  localparam int TIMEOUT = 1023;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic [1:0]  m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ysyx_25010008_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_arvalid = 0; m0_araddr = 0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = 0; m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    settle();
  endtask

  function automatic logic [63:0] all_valids();
    return {52'd0, m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
            m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
  endfunction

  initial begin
    clear_inputs();
    do_reset();

    // reset state
    chk("rst_state", dut.state, IDLE);
    chk("rst_err", err_timeout, 0);
    chk("rst_valids", all_valids(), 0);

    // 1: single IFU read
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; s_arready = 1; settle();
    chk("t1_idle_no_fwd", s_arvalid, 0);
    tick();
    chk("t1_s_arvalid", s_arvalid, 1);
    chk("t1_s_araddr", s_araddr, 32'h8000_0000);
    chk("t1_m0_arready", m0_arready, 1);
    tick();
    m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = OKAY; m0_rready = 1; settle();
    chk("t1_m0_rvalid", m0_rvalid, 1);
    chk("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("t1_m0_rresp", m0_rresp, 0);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    tick();
    s_rvalid = 0; m0_rready = 0; settle();
    chk("t1_back_idle", dut.state, IDLE);

    // 2: contention after reset, M0 first, then round-robin on re-request
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h100; m1_arvalid = 1; m1_araddr = 32'h200; s_arready = 1;
    tick();
    chk("t2_first_m0", s_araddr, 32'h100);
    chk("t2_m0_arready", m0_arready, 1);
    chk("t2_m1_blocked", m1_arready, 0);
    tick();
    m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h1111_0000; s_rresp = SLVERR; m0_rready = 1; settle();
    chk("t2_m0_rdata", m0_rdata, 32'h1111_0000);
    chk("t2_m0_rresp", m0_rresp, SLVERR);
    chk("t2_m1_no_rvalid", m1_rvalid, 0);
    tick();
    s_rvalid = 0; m0_rready = 0;
    m0_arvalid = 1; m0_araddr = 32'h300; settle();
    chk("t2_idle_gap", dut.state, IDLE);
    chk("t2_idle_m1_arready", m1_arready, 0);
    tick();
    chk("t2_second_m1", s_araddr, 32'h200);
    chk("t2_m1_arready", m1_arready, 1);
    chk("t2_m0_blocked", m0_arready, 0);
    tick();
    m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h2222_0000; s_rresp = DECERR; m1_rready = 1; settle();
    chk("t2_m1_rdata", m1_rdata, 32'h2222_0000);
    chk("t2_m1_rresp", m1_rresp, DECERR);
    chk("t2_m0_no_rvalid", m0_rvalid, 0);
    tick();
    s_rvalid = 0; m1_rready = 0; settle();
    chk("t2_idle_gap2", dut.state, IDLE);
    tick();
    chk("t2_third_m0", s_araddr, 32'h300);
    tick();
    m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h3333_0000; s_rresp = OKAY; m0_rready = 1; settle();
    chk("t2_m0_rdata2", m0_rdata, 32'h3333_0000);
    tick();
    s_rvalid = 0; m0_rready = 0; s_arready = 0; settle();

    // 3: LSU write, W handshakes before AW
    m1_awvalid = 1; m1_awaddr = 32'h8000_0010; m1_wvalid = 1; m1_wdata = 32'h1234_5678;
    m1_wstrb = 4'b0011; s_awready = 0; s_wready = 1; settle();
    chk("t3_idle_no_aw", s_awvalid, 0);
    tick();
    chk("t3_s_awvalid", s_awvalid, 1);
    chk("t3_s_awaddr", s_awaddr, 32'h8000_0010);
    chk("t3_s_wvalid", s_wvalid, 1);
    chk("t3_s_wdata", s_wdata, 32'h1234_5678);
    chk("t3_s_wstrb", s_wstrb, 4'b0011);
    chk("t3_m1_wready", m1_wready, 1);
    chk("t3_m1_awready_wait", m1_awready, 0);
    chk("t3_no_s_arvalid", s_arvalid, 0);
    tick();
    m1_wvalid = 0; s_awready = 1; settle();
    chk("t3_m1_awready", m1_awready, 1);
    chk("t3_w_done", s_wvalid, 0);
    tick();
    m1_awvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = OKAY; m1_bready = 1; settle();
    chk("t3_m1_bvalid", m1_bvalid, 1);
    chk("t3_m1_bresp", m1_bresp, 0);
    chk("t3_s_bready", s_bready, 1);
    tick();
    s_bvalid = 0; m1_bready = 0; settle();
    chk("t3_back_idle", dut.state, IDLE);

    // 4: SLVERR write response is forwarded untouched
    m1_awvalid = 1; m1_awaddr = 32'h40; m1_wvalid = 1; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF;
    s_awready = 1; s_wready = 1;
    tick();
    chk("t4_aw_w_same", {m1_awready, m1_wready}, 2'b11);
    tick();
    m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = SLVERR; m1_bready = 1; settle();
    chk("t4_m1_bresp", m1_bresp, SLVERR);
    tick();
    s_bvalid = 0; m1_bready = 0; settle();
    chk("t4_back_idle", dut.state, IDLE);
    chk("t4_err_clear", err_timeout, 0);

    // 5: slave never returns R; watchdog fires after TIMEOUT granted cycles
    m0_arvalid = 1; m0_araddr = 32'h500; s_arready = 1; m0_rready = 1;
    tick();
    m0_arvalid = 0; m1_arvalid = 1; m1_araddr = 32'h600;
    repeat (TIMEOUT - 1) tick();
    chk("t5_err_before", err_timeout, 0);
    tick();
    chk("t5_err_at_timeout", err_timeout, 1);
    chk("t5_grant_held", dut.state, M0_RD);
    chk("t5_m1_blocked", m1_arready, 0);
    repeat (5) tick();
    chk("t5_err_sticky", err_timeout, 1);
    chk("t5_still_held", dut.state, M0_RD);
    #2 reset = 1'b0; settle();
    chk("t5_reset_err", err_timeout, 0);
    do_reset();

    // 6: async reset while M1_RD has rvalid pending
    m1_arvalid = 1; m1_araddr = 32'h700; s_arready = 1;
    tick();
    tick();
    m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h7777_7777; m1_rready = 0; settle();
    chk("t6_rvalid_pending", m1_rvalid, 1);
    #2 reset = 1'b0; settle();
    chk("t6_async_valids", all_valids(), 0);
    chk("t6_async_rdata", m1_rdata, 0);
    chk("t6_state_idle", dut.state, IDLE);
    chk("t6_err", err_timeout, 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
